countdown_timer: RTL and testbench



---
 rtl/countdown_pkg.sv | 14 +
 rtl/bcd_down_digit.sv | 35 +++
 rtl/countdown_timer.sv | 134 +++++++++++++
 tb/tb_countdown_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and default sizes for the MM:SS countdown timer.
package countdown_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DIGIT_W_DEF      = 4;
  localparam int SEC_TENS_MAX_DEF = 5;
  localparam int MIN_TENS_MAX_DEF = 5;
  localparam int BCD_ONES_MAX     = 9;
endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit as a mod-(MOD_MAX+1) down counter with a combinational borrow out.
module bcd_down_digit #(
  parameter int DIGIT_W = 4,
  parameter int MOD_MAX = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  output logic [DIGIT_W-1:0] q,
  output logic               borrow,
  output logic               zero
);
  logic [DIGIT_W-1:0] q_reg, q_next;

  always_comb begin
    q_next = q_reg;
    if (ld)
      q_next = ld_val;
    else if (dec)
      q_next = (q_reg == '0) ? DIGIT_W'(MOD_MAX) : q_reg - DIGIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      q_reg <= '0;
    else
      q_reg <= q_next;
  end

  assign q      = q_reg;
  assign zero   = (q_reg == '0);
  assign borrow = dec & zero;
endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer: FSM, load validation, input priority and the digit borrow chain.
// Optional auto-reload from the last valid load is enabled by COUNTDOWN_AUTO_RELOAD_EN.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
  parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF,
  parameter int DIGIT_W      = DIGIT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_min_tens,
  input  logic [DIGIT_W-1:0] load_min_ones,
  input  logic [DIGIT_W-1:0] load_sec_tens,
  input  logic [DIGIT_W-1:0] load_sec_ones,
  input  logic               start,
  input  logic               stop,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               done,
  output logic               load_err
);
  state_t state_reg, state_next;
  logic   running_reg, done_reg, load_err_reg;
  logic   dec_en, reload, load_ok, load_bad, ld_en;
  logic   load_valid, is_zero, is_one, shadow_zero;
  logic   so_borrow, st_borrow, mo_borrow, mt_borrow;
  logic   so_zero, st_zero, mo_zero, mt_zero;
  logic [4*DIGIT_W-1:0] ld_vec;
  logic [4*DIGIT_W-1:0] load_vec;

  assign load_vec = {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones};

  assign load_valid = (load_sec_ones <= DIGIT_W'(BCD_ONES_MAX)) &&
                      (load_min_ones <= DIGIT_W'(BCD_ONES_MAX)) &&
                      (load_sec_tens <= DIGIT_W'(SEC_TENS_MAX)) &&
                      (load_min_tens <= DIGIT_W'(MIN_TENS_MAX));

  assign is_zero = so_zero & st_zero & mo_zero & mt_zero;
  assign is_one  = (sec_ones == DIGIT_W'(1)) & st_zero & mo_zero & mt_zero;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [4*DIGIT_W-1:0] shadow_reg;

  always_ff @(posedge clk) begin
    if (!rst)
      shadow_reg <= '0;
    else if (load_ok)
      shadow_reg <= load_vec;
  end

  assign shadow_zero = (shadow_reg == '0);
  assign ld_vec      = reload ? shadow_reg : load_vec;
`else
  assign shadow_zero = 1'b1;
  assign ld_vec      = load_vec;
`endif

  assign ld_en = load_ok | reload;

  // load > stop > start > tick; any load pulse, valid or not, consumes the cycle.
  always_comb begin
    state_next = state_reg;
    dec_en     = 1'b0;
    reload     = 1'b0;
    load_ok    = 1'b0;
    load_bad   = 1'b0;
    if (load) begin
      if (load_valid) begin
        load_ok    = 1'b1;
        state_next = IDLE;
      end else begin
        load_bad = 1'b1;
      end
    end else if (stop) begin
      if (state_reg == RUN)
        state_next = PAUSE;
    end else if (start && (state_reg == IDLE || state_reg == PAUSE) && !is_zero) begin
      state_next = RUN;
    end else if (tick && state_reg == RUN) begin
      if (is_one && !shadow_zero) begin
        reload = 1'b1;
      end else begin
        dec_en = 1'b1;
        if (is_one)
          state_next = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      running_reg  <= 1'b0;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      running_reg  <= (state_next == RUN);
      done_reg     <= (state_next == DONE) | reload;
      load_err_reg <= load_bad;
    end
  end

  bcd_down_digit #(.DIGIT_W(DIGIT_W), .MOD_MAX(BCD_ONES_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .dec(dec_en), .ld(ld_en), .ld_val(ld_vec[DIGIT_W-1:0]),
    .q(sec_ones), .borrow(so_borrow), .zero(so_zero)
  );

  bcd_down_digit #(.DIGIT_W(DIGIT_W), .MOD_MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .dec(so_borrow), .ld(ld_en), .ld_val(ld_vec[2*DIGIT_W-1:DIGIT_W]),
    .q(sec_tens), .borrow(st_borrow), .zero(st_zero)
  );

  bcd_down_digit #(.DIGIT_W(DIGIT_W), .MOD_MAX(BCD_ONES_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .dec(st_borrow), .ld(ld_en), .ld_val(ld_vec[3*DIGIT_W-1:2*DIGIT_W]),
    .q(min_ones), .borrow(mo_borrow), .zero(mo_zero)
  );

  // The minutes-tens borrow would mean underflow, which the FSM never allows.
  bcd_down_digit #(.DIGIT_W(DIGIT_W), .MOD_MAX(MIN_TENS_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .dec(mo_borrow), .ld(ld_en), .ld_val(ld_vec[4*DIGIT_W-1:3*DIGIT_W]),
    .q(min_tens), .borrow(mt_borrow), .zero(mt_zero)
  );

  assign running  = running_reg;
  assign done     = done_reg;
  assign load_err = load_err_reg;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: seconds-count reference model plus directed literal checks.
module tb_countdown_timer;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst, tick, load, start, stop;
  logic [3:0] l_mt, l_mo, l_st, l_so;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, load_err;

  int checks = 0;
  int errors = 0;

  int m_secs = 0, m_st = M_IDLE, m_shadow = 0;
  bit m_done = 0, m_err = 0;

  bit          chk_en = 0;
  bit          lit_pending = 0;
  string       lit_name = "";
  logic [18:0] lit_exp = '0;

  always #5 clk = ~clk;

  countdown_timer dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .load_min_tens(l_mt), .load_min_ones(l_mo), .load_sec_tens(l_st), .load_sec_ones(l_so),
    .start(start), .stop(stop),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .done(done), .load_err(load_err)
  );

  function automatic logic [15:0] to_bcd(input int s);
    int mins;
    mins = s / 60;
    return {4'(mins / 10), 4'(mins % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  // Reference: the timer is a seconds count; digits are just its MM:SS rendering.
  always @(posedge clk) begin : model
    int s, st, sh;
    bit dn, er;
    s = m_secs; st = m_st; sh = m_shadow; dn = 0; er = 0;
    if (!rst) begin
      s = 0; st = M_IDLE; sh = 0;
    end else if (load) begin
      if (l_mo <= 9 && l_so <= 9 && l_st <= 5 && l_mt <= 5) begin
        s  = (int'(l_mt) * 10 + int'(l_mo)) * 60 + int'(l_st) * 10 + int'(l_so);
        st = M_IDLE;
        sh = s;
      end else begin
        er = 1;
      end
    end else if (stop) begin
      if (st == M_RUN) st = M_PAUSE;
    end else if (start && (st == M_IDLE || st == M_PAUSE) && s != 0) begin
      st = M_RUN;
    end else if (tick && st == M_RUN) begin
      if (s == 1) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (sh != 0) begin s = sh; dn = 1; end
        else begin s = 0; st = M_DONE; end
`else
        s = 0; st = M_DONE;
`endif
      end else begin
        s = s - 1;
      end
    end
    if (st == M_DONE) dn = 1;
    m_secs   <= s;
    m_st     <= st;
    m_shadow <= sh;
    m_done   <= dn;
    m_err    <= er;
  end

  always @(negedge clk) begin
    logic [18:0] got, mexp;
    got  = {min_tens, min_ones, sec_tens, sec_ones, running, done, load_err};
    mexp = {to_bcd(m_secs), (m_st == M_RUN), m_done, m_err};
    if (chk_en) begin
      checks++;
      if (got !== mexp) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h expected=%h", $time, got, mexp);
      end
    end
    if (lit_pending) begin
      checks++;
      if (got !== lit_exp) begin
        errors++;
        $display("FAIL %s dut got=%h expected=%h", lit_name, got, lit_exp);
      end
      checks++;
      if (mexp !== lit_exp) begin
        errors++;
        $display("FAIL %s model got=%h expected=%h", lit_name, mexp, lit_exp);
      end
    end
  end

  task automatic step(input bit t, input bit ld, input bit sa, input bit so);
    tick = t; load = ld; start = sa; stop = so;
    @(posedge clk);
    #1;
    tick = 0; load = 0; start = 0; stop = 0;
  endtask

  task automatic do_load(input logic [15:0] v);
    {l_mt, l_mo, l_st, l_so} = v;
    step(0, 1, 0, 0);
  endtask

  task automatic expect_out(input string name, input logic [15:0] dig,
                            input bit run, input bit dn, input bit er);
    lit_name    = name;
    lit_exp     = {dig, run, dn, er};
    lit_pending = 1;
    @(negedge clk);
    #1;
    lit_pending = 0;
    $display("txn %s: expect %h run=%0b done=%0b err=%0b", name, dig, run, dn, er);
  endtask

  initial begin
    logic [15:0] v;
    int r;
    rst = 0; tick = 0; load = 0; start = 0; stop = 0;
    {l_mt, l_mo, l_st, l_so} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    expect_out("reset", 16'h0000, 0, 0, 0);
    rst = 1;

    do_load(16'h0105);  expect_out("load_0105", 16'h0105, 0, 0, 0);
    step(0, 0, 1, 0);   expect_out("start_0105", 16'h0105, 1, 0, 0);
    step(1, 0, 0, 0);   expect_out("tick_0104", 16'h0104, 1, 0, 0);
    step(1, 0, 0, 0);   expect_out("tick_0103", 16'h0103, 1, 0, 0);
    step(1, 0, 0, 0);   expect_out("tick_0102", 16'h0102, 1, 0, 0);
    step(1, 0, 0, 0);   expect_out("tick_0101", 16'h0101, 1, 0, 0);
    step(1, 0, 0, 0);   expect_out("tick_0100", 16'h0100, 1, 0, 0);
    step(1, 0, 0, 0);   expect_out("borrow_0059", 16'h0059, 1, 0, 0);

    do_load(16'h0002);  expect_out("abort_load_0002", 16'h0002, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);   expect_out("tick_0001", 16'h0001, 1, 0, 0);
    step(1, 0, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    expect_out("reload_0002", 16'h0002, 1, 1, 0);
    step(0, 0, 0, 0);   expect_out("reload_done_pulse", 16'h0002, 1, 0, 0);
`else
    expect_out("expire_0000", 16'h0000, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0);
    expect_out("done_hold", 16'h0000, 0, 1, 0);
    step(0, 0, 1, 0);   expect_out("start_in_done", 16'h0000, 0, 1, 0);
`endif

    do_load(16'h0010);  expect_out("load_0010", 16'h0010, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 1);   expect_out("stop_with_tick", 16'h0010, 0, 0, 0);
    step(1, 0, 0, 0);   expect_out("tick_in_pause", 16'h0010, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);   expect_out("resume_0009", 16'h0009, 1, 0, 0);

    do_load(16'h0300);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);   expect_out("pause_0300", 16'h0300, 0, 0, 0);
    do_load(16'h0360);  expect_out("bad_sec_tens", 16'h0300, 0, 0, 1);
    step(0, 0, 0, 0);   expect_out("err_one_cycle", 16'h0300, 0, 0, 0);
    step(0, 0, 1, 0);   expect_out("run_0300", 16'h0300, 1, 0, 0);
    do_load(16'h030A);  expect_out("bad_sec_ones", 16'h0300, 1, 0, 1);

    do_load(16'h0000);
    step(0, 0, 1, 0);   expect_out("start_at_zero", 16'h0000, 0, 0, 0);
    do_load(16'h0105);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);   expect_out("run_0104", 16'h0104, 1, 0, 0);
    do_load(16'h5959);  expect_out("load_5959_mid_run", 16'h5959, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);   expect_out("idle_ticks_ignored", 16'h5959, 0, 0, 0);

    // Randomized traffic checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)
        v = 16'($urandom_range(0, 65535));
      else if (r < 7)
        v = to_bcd($urandom_range(0, 4));
      else
        v = to_bcd($urandom_range(0, 3599));
      {l_mt, l_mo, l_st, l_so} = v;
      rst   = ($urandom_range(0, 999) != 0);
      tick  = ($urandom_range(0, 1) == 1);
      load  = ($urandom_range(0, 24) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      if (load)
        $display("txn rand_load %0d: value %h", i, v);
      @(posedge clk);
      #1;
      tick = 0; load = 0; start = 0; stop = 0; rst = 1;
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
